spi_45: RTL and testbench



---
 rtl/spi_45_pkg.sv | 48 ++++
 rtl/spi_45_byte_tx.sv | 44 ++++
 rtl/spi_45.sv | 146 ++++++++++++++
 tb/tb_spi_45.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/spi_45_pkg.sv
// Shared types and constants for the 45-degree SPI line-drawing engine.
package spi_45_pkg;

  localparam int unsigned BYTES_PER_PIXEL = 13;
  localparam int unsigned IDX_W           = 4;
  localparam int unsigned CNT_W           = 3;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } state_t;

  // One serialised byte together with its data/command flag.
  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } tx_byte_t;

  // Byte at position idx of a single pixel transaction.
  function automatic tx_byte_t pixel_byte(input logic [IDX_W-1:0] idx,
                                          input logic [15:0]      x,
                                          input logic [15:0]      y,
                                          input logic [15:0]      color);
    tx_byte_t b;
    b.dc   = 1'b1;
    b.data = 8'h00;
    case (idx)
      4'd0:        begin b.dc = 1'b0; b.data = CMD_CASET; end
      4'd1, 4'd3:  b.data = x[15:8];
      4'd2, 4'd4:  b.data = x[7:0];
      4'd5:        begin b.dc = 1'b0; b.data = CMD_PASET; end
      4'd6, 4'd8:  b.data = y[15:8];
      4'd7, 4'd9:  b.data = y[7:0];
      4'd10:       begin b.dc = 1'b0; b.data = CMD_RAMWR; end
      4'd11:       b.data = color[15:8];
      4'd12:       b.data = color[7:0];
      default:     b.data = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_45_byte_tx.sv
// Byte serialiser: loads a byte with its dc flag and shifts it out MSB first.
// When neither loading nor shifting it clears, so mosi/dc idle at 0.
module spi_45_byte_tx
  import spi_45_pkg::*;
(
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     load,
  input  logic     shift,
  input  tx_byte_t byte_in,
  output logic     mosi,
  output logic     dc,
  output logic     last_c
);

  logic [7:0]       sr_q;
  logic             dc_q;
  logic [CNT_W-1:0] cnt_q;

  // Shift register, dc latch and bit counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      sr_q  <= 8'h00;
      dc_q  <= 1'b0;
      cnt_q <= '0;
    end else if (load) begin
      sr_q  <= byte_in.data;
      dc_q  <= byte_in.dc;
      cnt_q <= '0;
    end else if (shift) begin
      sr_q  <= {sr_q[6:0], 1'b0};
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      sr_q  <= 8'h00;
      dc_q  <= 1'b0;
      cnt_q <= '0;
    end
  end

  assign mosi   = sr_q[7];
  assign dc     = dc_q;
  assign last_c = (cnt_q == CNT_W'(7));

endmodule

// File: rtl/spi_45.sv
// 45-degree line drawer: emits one CASET/PASET/RAMWR SPI transaction per pixel.
module spi_45
  import spi_45_pkg::*;
#(
  parameter int unsigned DELAY = 20,
  parameter logic [15:0] X1    = 16'd0,
  parameter logic [15:0] X2    = 16'd5,
  parameter logic [15:0] Y1    = 16'd0,
  parameter logic [15:0] Y2    = 16'd5,
  parameter logic [15:0] COLOR = 16'hFFFF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  output logic o_mosi,
  output logic o_dc,
  output logic o_cs,
  output logic o_done
);

  localparam int unsigned PIX_W    = 17;
  localparam int unsigned GAP_W    = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam int unsigned SPAN     = (X2 >= X1) ? (32'(X2) - 32'(X1)) : (32'(X1) - 32'(X2));
  localparam int unsigned N_PIX    = SPAN + 1;
  localparam logic [15:0] X_STEP   = (X2 > X1) ? 16'd1 : ((X2 < X1) ? 16'hFFFF : 16'd0);
  localparam logic [15:0] Y_STEP   = (Y2 > Y1) ? 16'd1 : ((Y2 < Y1) ? 16'hFFFF : 16'd0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_PIXEL - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [15:0]       x_q, x_d;
  logic [15:0]       y_q, y_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              cs_q, cs_d;
  logic              done_q, done_d;

  logic              tx_load, tx_shift, tx_last_c;
  tx_byte_t          tx_in;

  spi_45_byte_tx u_tx (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .load    (tx_load),
    .shift   (tx_shift),
    .byte_in (tx_in),
    .mosi    (o_mosi),
    .dc      (o_dc),
    .last_c  (tx_last_c)
  );

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      pix_q   <= '0;
      x_q     <= 16'd0;
      y_q     <= 16'd0;
      gap_q   <= '0;
      cs_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pix_q   <= pix_d;
      x_q     <= x_d;
      y_q     <= y_d;
      gap_q   <= gap_d;
      cs_q    <= cs_d;
      done_q  <= done_d;
    end
  end

  // Next-state, byte sequencing and coordinate stepping.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pix_d    = pix_q;
    x_d      = x_q;
    y_d      = y_q;
    gap_d    = gap_q;
    cs_d     = cs_q;
    done_d   = 1'b0;
    tx_load  = 1'b0;
    tx_shift = 1'b0;
    tx_in    = pixel_byte(idx_q, x_q, y_q, COLOR);

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_SEND;
          x_d     = X1;
          y_d     = Y1;
          pix_d   = '0;
          idx_d   = '0;
          cs_d    = 1'b0;
          tx_load = 1'b1;
          tx_in   = pixel_byte(IDX_W'(0), X1, Y1, COLOR);
        end
      end
      ST_SEND: begin
        if (!tx_last_c) begin
          tx_shift = 1'b1;
        end else if (idx_q != LAST_IDX) begin
          idx_d   = idx_q + IDX_W'(1);
          tx_load = 1'b1;
          tx_in   = pixel_byte(idx_q + IDX_W'(1), x_q, y_q, COLOR);
        end else begin
          cs_d = 1'b1;
          if (pix_q == PIX_W'(N_PIX - 1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_GAP;
            gap_d   = '0;
            x_d     = x_q + X_STEP;
            y_d     = y_q + Y_STEP;
            pix_d   = pix_q + PIX_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(DELAY - 1)) begin
          state_d = ST_SEND;
          idx_d   = '0;
          cs_d    = 1'b0;
          tx_load = 1'b1;
          tx_in   = pixel_byte(IDX_W'(0), x_q, y_q, COLOR);
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_cs   = cs_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_spi_45.sv
// Bench for spi_45: per-cycle comparison of cs/dc/mosi/done against a byte-level model.
module tb_spi_45;

  localparam int A_DELAY = 20;
  localparam int A_X1 = 0, A_X2 = 5, A_Y1 = 0, A_Y2 = 5;
  localparam int A_COL = 16'hFFFF;
  localparam int B_DELAY = 3;
  localparam int B_X1 = 5, B_X2 = 0, B_Y1 = 5, B_Y2 = 0;
  localparam int B_COL = 16'hA5C3;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b;
  logic mosi_a, dc_a, cs_a, done_a;
  logic mosi_b, dc_b, cs_b, done_b;

  always #5 clk = ~clk;

  spi_45 #(.DELAY(A_DELAY), .X1(16'(A_X1)), .X2(16'(A_X2)), .Y1(16'(A_Y1)),
           .Y2(16'(A_Y2)), .COLOR(16'(A_COL))) u_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a),
    .o_mosi(mosi_a), .o_dc(dc_a), .o_cs(cs_a), .o_done(done_a));

  spi_45 #(.DELAY(B_DELAY), .X1(16'(B_X1)), .X2(16'(B_X2)), .Y1(16'(B_Y1)),
           .Y2(16'(B_Y2)), .COLOR(16'(B_COL))) u_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b),
    .o_mosi(mosi_b), .o_dc(dc_b), .o_cs(cs_b), .o_done(done_b));

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] exp_q[$];
  bit chained = 1'b0;

  // Observed {cs, dc, mosi, done} of the selected instance.
  function automatic logic [3:0] obs(input bit sel);
    return sel ? {cs_b, dc_b, mosi_b, done_b} : {cs_a, dc_a, mosi_a, done_a};
  endfunction

  task automatic check(input string tag, input int cyc, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, o, e);
    end
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) start_b = v; else start_a = v;
  endtask

  // Expected per-cycle pin stream for one whole line, starting the cycle after start.
  task automatic build_exp(input bit sel, output int busy, output int n);
    int x, y, sx, sy, x1, x2, y1, y2, dly, col;
    logic [15:0] xv, yv, cv;
    logic [8:0] tr [13];
    x1 = sel ? B_X1 : A_X1;  x2 = sel ? B_X2 : A_X2;
    y1 = sel ? B_Y1 : A_Y1;  y2 = sel ? B_Y2 : A_Y2;
    dly = sel ? B_DELAY : A_DELAY;
    col = sel ? B_COL : A_COL;
    sx = (x2 > x1) ? 1 : ((x2 < x1) ? -1 : 0);
    sy = (y2 > y1) ? 1 : ((y2 < y1) ? -1 : 0);
    n  = ((x2 >= x1) ? (x2 - x1) : (x1 - x2)) + 1;
    exp_q.delete();
    x = x1;
    y = y1;
    cv = 16'(col);
    for (int p = 0; p < n; p++) begin
      xv = 16'(x);
      yv = 16'(y);
      tr[0]  = {1'b0, 8'h2A};
      tr[1]  = {1'b1, xv[15:8]}; tr[2] = {1'b1, xv[7:0]};
      tr[3]  = {1'b1, xv[15:8]}; tr[4] = {1'b1, xv[7:0]};
      tr[5]  = {1'b0, 8'h2B};
      tr[6]  = {1'b1, yv[15:8]}; tr[7] = {1'b1, yv[7:0]};
      tr[8]  = {1'b1, yv[15:8]}; tr[9] = {1'b1, yv[7:0]};
      tr[10] = {1'b0, 8'h2C};
      tr[11] = {1'b1, cv[15:8]}; tr[12] = {1'b1, cv[7:0]};
      for (int k = 0; k < 13; k++)
        for (int b = 7; b >= 0; b--)
          exp_q.push_back({1'b0, tr[k][8], tr[k][b], 1'b0});
      if (p < n - 1)
        repeat (dly) exp_q.push_back(4'b1000);
      x = (x + sx) & 16'hFFFF;
      y = (y + sy) & 16'hFFFF;
    end
    exp_q.push_back(4'b1001);
    exp_q.push_back(4'b1000);
    busy = n * 104 + (n - 1) * dly + 1;
  endtask

  // Draw one line on the selected instance, optionally poking start while busy,
  // on the done cycle, right after done (chain), or resetting mid-line.
  task automatic run_line(input bit sel, input int busy_at, input bit poke_done,
                          input bit chain_next, input int abort_at);
    int busy, n, lows, dones, done_cyc;
    logic [3:0] o;
    build_exp(sel, busy, n);
    if (!chained) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        check("idle", 0, 32'(obs(sel)), 32'(4'b1000));
      end
      @(negedge clk);
      set_start(sel, 1'b1);
    end
    chained  = 1'b0;
    lows     = 0;
    dones    = 0;
    done_cyc = 0;
    for (int c = 1; c <= busy + 1; c++) begin
      @(negedge clk);
      set_start(sel, (c == busy_at) || (poke_done && c == busy) || (chain_next && c == busy + 1));
      rst = !(abort_at != 0 && c == abort_at);
      o = obs(sel);
      if (abort_at != 0 && c == abort_at + 1) begin
        check("abort", c, 32'(o), 32'(4'b1000));
        break;
      end
      check(sel ? "rev" : "fwd", c, 32'(o), 32'(exp_q[c-1]));
      if (!o[3]) lows++;
      if (o[0]) begin dones++; done_cyc = c; end
    end
    rst = 1'b1;
    if (abort_at == 0) begin
      check("cs_low_cycles", 0, 32'(lows), 32'(n * 104));
      check("done_count", 0, 32'(dones), 32'd1);
      check("done_cycle", 0, 32'(done_cyc), 32'(busy));
    end else begin
      repeat (3) begin
        @(negedge clk);
        check("post_abort", 0, 32'(obs(sel)), 32'(4'b1000));
      end
    end
    chained = chain_next;
  endtask

  initial begin
    rst     = 1'b0;
    start_a = 1'b1;
    start_b = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_a", 0, 32'(obs(1'b0)), 32'(4'b1000));
      check("rst_b", 0, 32'(obs(1'b1)), 32'(4'b1000));
    end
    rst     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    @(negedge clk);
    check("idle_a", 0, 32'(obs(1'b0)), 32'(4'b1000));
    check("idle_b", 0, 32'(obs(1'b1)), 32'(4'b1000));

    run_line(1'b0, 0, 1'b0, 1'b0, 0);
    run_line(1'b1, 0, 1'b0, 1'b0, 0);
    run_line(1'b0, $urandom_range(5, 700), 1'b1, 1'b1, 0);
    run_line(1'b0, 0, 1'b0, 1'b0, 0);
    run_line(1'b0, 0, 1'b0, 1'b0, $urandom_range(249, 352));
    run_line(1'b0, 0, 1'b0, 1'b0, 0);
    run_line(1'b1, $urandom_range(5, 600), 1'b1, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
